// File: rtl/sw_debounce.sv
// sw_debounce: per-bit two-flop synchronizer and counter-based debouncer
// with registered rise/fall pulses and an any-change flag.
module sw_debounce #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1, sync2, hit;
   logic [CW-1:0]    cnt [WIDTH];

   // hit marks bits whose new level has persisted long enough to be accepted
   always_comb begin
      hit = '0;
      for (int i = 0; i < WIDTH; i++)
         hit[i] = (sync2[i] != sw_db[i]) && (cnt[i] == TERM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= '0;
         sync2      <= '0;
         sw_db      <= '0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         sw_changed <= 1'b0;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         sync1      <= sw_raw;
         sync2      <= sync1;
         sw_db      <= sw_db ^ hit;
         sw_rise    <= hit & sync2;
         sw_fall    <= hit & ~sync2;
         sw_changed <= |hit;
         for (int i = 0; i < WIDTH; i++)
            cnt[i] <= (sync2[i] == sw_db[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
      end
   end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scoreboard bench for sw_debounce with DEBOUNCE_CYCLES=4;
// expected outputs are queued per clock edge and compared on the falling edge.
module tb_sw_debounce;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw_raw = 8'h00;
   logic [7:0] sw_db, sw_rise, sw_fall;
   logic       sw_changed;

   sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
      .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at;
      logic [7:0] db, rise, fall;
      logic       chg;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0, bad = 0, cyc = 0, base = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (q.size() != 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         total++;
         if ({sw_db, sw_rise, sw_fall, sw_changed} !== {e.db, e.rise, e.fall, e.chg} || e.at != cyc) begin
            bad++;
            $display("FAIL sb edge=%0d want_edge=%0d: got db=%h rise=%h fall=%h chg=%b, want db=%h rise=%h fall=%h chg=%b",
                     cyc, e.at, sw_db, sw_rise, sw_fall, sw_changed, e.db, e.rise, e.fall, e.chg);
         end
      end

   task automatic push(input int at, input logic [7:0] d, r, f, input logic c);
      exp_t x;
      x.at = at; x.db = d; x.rise = r; x.fall = f; x.chg = c;
      q.push_back(x);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({sw_db, sw_rise, sw_fall, sw_changed} !== 25'h0) begin
         bad++;
         $display("FAIL reset: got db=%h rise=%h fall=%h chg=%b, want all 0", sw_db, sw_rise, sw_fall, sw_changed);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push(cyc + 8, 8'h00, 8'h00, 8'h00, 1'b0);
      drain();
   endtask

   task automatic test_change(input logic [7:0] from, to);
      @(negedge clk);
      sw_raw = to;
      base = cyc;
      for (int k = 1; k <= 5; k++) push(base + k, from, 8'h00, 8'h00, 1'b0);
      push(base + 6, to, to & ~from, from & ~to, 1'b1);
      for (int k = 7; k <= 9; k++) push(base + k, to, 8'h00, 8'h00, 1'b0);
      drain();
   endtask

   task automatic test_glitch();
      @(negedge clk);
      sw_raw = 8'h01;
      base = cyc;
      for (int k = 1; k <= 10; k++) push(base + k, 8'h00, 8'h00, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      sw_raw = 8'h00;
      drain();
   endtask

   task automatic test_bounce();
      @(negedge clk);
      sw_raw = 8'h01;
      base = cyc;
      for (int k = 1; k <= 7; k++) push(base + k, 8'h00, 8'h00, 8'h00, 1'b0);
      push(base + 8, 8'h01, 8'h01, 8'h00, 1'b1);
      for (int k = 9; k <= 14; k++) push(base + k, 8'h01, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      sw_raw = 8'h00;
      @(negedge clk);
      sw_raw = 8'h01;
      drain();
   endtask

   task automatic test_reset_mid_count();
      @(negedge clk);
      sw_raw = 8'hF0;
      base = cyc;
      for (int k = 1; k <= 4; k++) push(base + k, 8'h0F, 8'h00, 8'h00, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({sw_db, sw_rise, sw_fall, sw_changed} !== 25'h0) begin
         bad++;
         $display("FAIL reset_mid_count: got db=%h rise=%h fall=%h chg=%b, want all 0", sw_db, sw_rise, sw_fall, sw_changed);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      for (int k = 1; k <= 5; k++) push(base + k, 8'h00, 8'h00, 8'h00, 1'b0);
      push(base + 6, 8'hF0, 8'hF0, 8'h00, 1'b1);
      push(base + 7, 8'hF0, 8'h00, 8'h00, 1'b0);
      drain();
   endtask

   task automatic test_high_through_reset();
      @(negedge clk);
      sw_raw = 8'hA5;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (sw_db !== 8'h00) begin
         bad++;
         $display("FAIL high_through_reset: got db=%h, want 00", sw_db);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      for (int k = 1; k <= 5; k++) push(base + k, 8'h00, 8'h00, 8'h00, 1'b0);
      push(base + 6, 8'hA5, 8'hA5, 8'h00, 1'b1);
      for (int k = 7; k <= 9; k++) push(base + k, 8'hA5, 8'h00, 8'h00, 1'b0);
      drain();
   endtask

   initial begin
      test_reset();
      test_change(8'h00, 8'h01);
      test_change(8'h01, 8'h00);
      test_glitch();
      test_bounce();
      test_change(8'h01, 8'hFF);
      test_change(8'hFF, 8'h0F);
      test_reset_mid_count();
      test_high_through_reset();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d pending expectations, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
